cpu_int_multi: RTL and testbench

Multi-channel maskable-interrupt generator for the Z80 core, clocked by the CPU clock so pulse width is counted in T-states at every turbo setting. Each channel fires on a programmable raster position (vc/hc). Channels are arbitrated by fixed priority onto the single /INT line. Also provides an IM2 vector, an INTA handshake, and per-channel missed-interrupt flags. Sits beside the CPU clock/contention logic and replaces the fixed single-position INT generator.

---
 rtl/cpu_int_multi.sv | 127 ++++++++++++
 tb/tb_cpu_int_multi.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_int_multi.sv
// Multi-channel maskable interrupt generator on the CPU clock: raster-position
// triggers, fixed-priority arbitration onto /INT, IM2 vector, INTA handshake.
module cpu_int_multi #(
    parameter int CHANNELS = 4,
    parameter int VW       = 9,
    parameter int HW       = 9,
    parameter int PW_W     = 6
) (
    input  logic                   clkcpu,
    input  logic                   rst_n,
    input  logic [VW-1:0]          vc,
    input  logic [HW-1:0]          hc,
    input  logic [CHANNELS*VW-1:0] trig_v,
    input  logic [CHANNELS*HW-1:0] trig_h,
    input  logic [CHANNELS-1:0]    enable,
    input  logic [PW_W-1:0]        pulse_len,
    input  logic [7:0]             vector_base,
    input  logic                   m1,
    input  logic                   iorq,
    output logic                   n_int,
    output logic [7:0]             int_vector,
    output logic [2:0]             active_ch,
    output logic [CHANNELS-1:0]    pending,
    output logic [CHANNELS-1:0]    missed,
    output logic                   ack
);

    typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

    state_t              state_q, state_d;
    logic [CHANNELS-1:0] match, matchPrev_q;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] missed_q, missed_d;
    logic [CHANNELS-1:0] effPending, chMask, activeMask, clrMask, dropMask;
    logic [PW_W-1:0]     cnt_q, cnt_d;
    logic [2:0]          ch_q, ch_d, sel;
    logic [7:0]          vector_q, vector_d;
    logic                ack_q, ack_d;

    // Per-channel raster compare, priority select and the active-channel mask.
    always_comb begin
        match      = '0;
        chMask     = '0;
        sel        = '0;
        effPending = pending_q & enable;
        for (int i = 0; i < CHANNELS; i++) begin
            match[i]  = (vc == trig_v[i*VW +: VW]) && (hc == trig_h[i*HW +: HW]);
            chMask[i] = (ch_q == 3'(i));
        end
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (effPending[i]) sel = 3'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        vector_d = vector_q;
        ack_d    = 1'b0;
        clrMask  = '0;
        missed_d = missed_q;
        case (state_q)
            IDLE: begin
                if (|effPending) begin
                    ch_d     = sel;
                    cnt_d    = (pulse_len == '0) ? PW_W'(1) : pulse_len;
                    vector_d = vector_base + {4'b0000, sel, 1'b0};
                    state_d  = ASSERT;
                end
            end
            ASSERT: begin
                if (m1 && iorq) begin
                    ack_d    = 1'b1;
                    clrMask  = chMask;
                    missed_d = missed_q & ~chMask;
                    state_d  = GAP;
                end else if (cnt_q == PW_W'(1)) begin
                    clrMask  = chMask;
                    missed_d = missed_q | chMask;
                    state_d  = GAP;
                end else begin
                    cnt_d = cnt_q - PW_W'(1);
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A fresh edge in the same cycle as a clear wins, so no event is lost.
    always_comb begin
        activeMask = (state_q == ASSERT) ? chMask : '0;
        dropMask   = ~enable & ~activeMask;
        pending_d  = (pending_q & ~clrMask & ~dropMask) | (match & ~matchPrev_q & enable);
    end

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            matchPrev_q <= '0;
            pending_q   <= '0;
            missed_q    <= '0;
            cnt_q       <= '0;
            ch_q        <= '0;
            vector_q    <= '0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            matchPrev_q <= match;
            pending_q   <= pending_d;
            missed_q    <= missed_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            vector_q    <= vector_d;
            ack_q       <= ack_d;
        end
    end

    assign n_int      = (state_q != ASSERT);
    assign int_vector = vector_q;
    assign active_ch  = ch_q;
    assign pending    = pending_q;
    assign missed     = missed_q;
    assign ack        = ack_q;

endmodule

// File: tb/tb_cpu_int_multi.sv
// Directed bench for cpu_int_multi: pulse width, INTA, priority, held match,
// enable masking and asynchronous reset, with hand-computed expectations.
module tb_cpu_int_multi;

    logic        clkcpu = 1'b0;
    logic        rst_n;
    logic [8:0]  vc, hc;
    logic [35:0] trig_v, trig_h;
    logic [3:0]  enable;
    logic [5:0]  pulse_len;
    logic [7:0]  vector_base;
    logic        m1, iorq;
    logic        n_int;
    logic [7:0]  int_vector;
    logic [2:0]  active_ch;
    logic [3:0]  pending, missed;
    logic        ack;

    int checks   = 0;
    int failures = 0;
    int lowCount;
    int fallCount;
    logic prevN;

    cpu_int_multi dut (
        .clkcpu(clkcpu), .rst_n(rst_n), .vc(vc), .hc(hc),
        .trig_v(trig_v), .trig_h(trig_h), .enable(enable),
        .pulse_len(pulse_len), .vector_base(vector_base),
        .m1(m1), .iorq(iorq), .n_int(n_int), .int_vector(int_vector),
        .active_ch(active_ch), .pending(pending), .missed(missed), .ack(ack)
    );

    always #5 clkcpu = ~clkcpu;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clkcpu);
        #1;
    endtask

    task automatic applyStimulus(input logic [8:0] v, input logic [8:0] h);
        vc = v;
        hc = h;
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts consecutive low cycles after a sample already seen low.
    task automatic measureLow(output int lows);
        lows = 1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (n_int == 1'b0) lows++;
            else break;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        applyStimulus(9'd100, 9'd100);
        trig_v      = {9'd20, 9'd10, 9'd10, 9'd248};
        trig_h      = {9'd7,  9'd5,  9'd5,  9'd0};
        enable      = 4'b0001;
        pulse_len   = 6'd32;
        vector_base = 8'hFF;
        m1          = 1'b0;
        iorq        = 1'b0;
        #12;
        checkOutput("reset_nint", int'(n_int), 1);
        checkOutput("reset_pending", int'(pending), 0);
        checkOutput("reset_missed", int'(missed), 0);
        checkOutput("reset_vector", int'(int_vector), 0);
        checkOutput("reset_active", int'(active_ch), 0);
        checkOutput("reset_ack", int'(ack), 0);
        rst_n = 1'b1;
        tick();

        // Ch0, pulse 32, no INTA
        applyStimulus(9'd248, 9'd0);
        tick();
        applyStimulus(9'd100, 9'd100);
        checkOutput("t1_pending_set", int'(pending), 1);
        checkOutput("t1_nint_latency", int'(n_int), 1);
        tick();
        checkOutput("t1_nint_fall", int'(n_int), 0);
        measureLow(lowCount);
        checkOutput("t1_low_len", lowCount, 32);
        checkOutput("t1_missed", int'(missed), 1);
        checkOutput("t1_pending_clr", int'(pending), 0);
        checkOutput("t1_vector", int'(int_vector), 8'hFF);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Ch0 with INTA ten cycles into the pulse
        applyStimulus(9'd248, 9'd0);
        tick();
        applyStimulus(9'd100, 9'd100);
        tick();
        checkOutput("t2_nint_fall", int'(n_int), 0);
        for (int c = 0; c < 9; c++) tick();
        checkOutput("t2_still_low", int'(n_int), 0);
        m1   = 1'b1;
        iorq = 1'b1;
        tick();
        m1   = 1'b0;
        iorq = 1'b0;
        checkOutput("t2_nint_rel", int'(n_int), 1);
        checkOutput("t2_ack", int'(ack), 1);
        checkOutput("t2_missed", int'(missed), 0);
        checkOutput("t2_vector", int'(int_vector), 8'hFF);
        checkOutput("t2_pending", int'(pending), 0);
        tick();
        checkOutput("t2_ack_pulse", int'(ack), 0);
        checkOutput("t2_gap", int'(n_int), 1);
        tick();

        // Ch1 and ch2 together, both acknowledged
        vector_base = 8'h10;
        enable      = 4'b0110;
        applyStimulus(9'd10, 9'd5);
        tick();
        applyStimulus(9'd100, 9'd100);
        checkOutput("t3_pending_both", int'(pending), 6);
        tick();
        checkOutput("t3_first_low", int'(n_int), 0);
        checkOutput("t3_first_ch", int'(active_ch), 1);
        checkOutput("t3_first_vec", int'(int_vector), 8'h12);
        m1   = 1'b1;
        iorq = 1'b1;
        tick();
        m1   = 1'b0;
        iorq = 1'b0;
        checkOutput("t3_first_ack", int'(ack), 1);
        checkOutput("t3_pending_ch2", int'(pending), 4);
        tick();
        checkOutput("t3_gap_high", int'(n_int), 1);
        checkOutput("t3_hold_vec", int'(int_vector), 8'h12);
        tick();
        checkOutput("t3_second_low", int'(n_int), 0);
        checkOutput("t3_second_ch", int'(active_ch), 2);
        checkOutput("t3_second_vec", int'(int_vector), 8'h14);
        m1   = 1'b1;
        iorq = 1'b1;
        tick();
        m1   = 1'b0;
        iorq = 1'b0;
        checkOutput("t3_second_ack", int'(ack), 1);
        checkOutput("t3_pending_none", int'(pending), 0);
        tick();
        tick();

        // Match held for 20 cycles fires once
        enable    = 4'b0001;
        pulse_len = 6'd3;
        applyStimulus(9'd248, 9'd0);
        lowCount  = 0;
        fallCount = 0;
        prevN     = n_int;
        for (int c = 0; c < 30; c++) begin
            if (c == 20) applyStimulus(9'd100, 9'd100);
            tick();
            if (n_int == 1'b0) lowCount++;
            if (prevN && !n_int) fallCount++;
            prevN = n_int;
        end
        checkOutput("t4_held_pulses", fallCount, 1);
        checkOutput("t4_held_low", lowCount, 3);
        checkOutput("t4_missed", int'(missed), 1);

        // Zero pulse length behaves as one
        pulse_len = 6'd0;
        applyStimulus(9'd248, 9'd0);
        tick();
        applyStimulus(9'd100, 9'd100);
        lowCount = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (n_int == 1'b0) lowCount++;
        end
        checkOutput("t4_zero_len", lowCount, 1);

        // Enable dropped for a waiting channel
        pulse_len = 6'd4;
        enable    = 4'b1001;
        applyStimulus(9'd248, 9'd0);
        tick();
        applyStimulus(9'd20, 9'd7);
        tick();
        applyStimulus(9'd100, 9'd100);
        checkOutput("t5_ch0_low", int'(n_int), 0);
        checkOutput("t5_pending_both", int'(pending), 9);
        enable = 4'b0001;
        tick();
        checkOutput("t5_pending_drop", int'(pending), 1);
        fallCount = 0;
        prevN     = n_int;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (prevN && !n_int) fallCount++;
            prevN = n_int;
        end
        checkOutput("t5_no_pulse", fallCount, 0);
        checkOutput("t5_idle_high", int'(n_int), 1);

        // Enable dropped for the active channel
        enable = 4'b1000;
        applyStimulus(9'd20, 9'd7);
        tick();
        applyStimulus(9'd100, 9'd100);
        tick();
        checkOutput("t5_ch3_low", int'(n_int), 0);
        checkOutput("t5_ch3_active", int'(active_ch), 3);
        enable = 4'b0000;
        measureLow(lowCount);
        checkOutput("t5_ch3_len", lowCount, 4);
        checkOutput("t5_missed", int'(missed), 9);
        checkOutput("t5_pending_end", int'(pending), 0);
        tick();

        // Asynchronous reset mid-pulse
        enable    = 4'b0001;
        pulse_len = 6'd8;
        applyStimulus(9'd248, 9'd0);
        tick();
        applyStimulus(9'd100, 9'd100);
        tick();
        checkOutput("t6_low_before", int'(n_int), 0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_nint", int'(n_int), 1);
        checkOutput("t6_async_missed", int'(missed), 0);
        checkOutput("t6_async_pending", int'(pending), 0);
        checkOutput("t6_async_vector", int'(int_vector), 0);
        #1;
        rst_n = 1'b1;
        tick();
        vector_base = 8'h20;
        applyStimulus(9'd248, 9'd0);
        tick();
        applyStimulus(9'd100, 9'd100);
        checkOutput("t6_refire_pending", int'(pending), 1);
        tick();
        checkOutput("t6_refire_low", int'(n_int), 0);
        checkOutput("t6_refire_vec", int'(int_vector), 8'h20);
        checkOutput("t6_refire_ch", int'(active_ch), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
